multi_debouncer: RTL and testbench

MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

---
 rtl/multi_debouncer.sv | 90 +++++++++
 tb/tb_multi_debouncer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/multi_debouncer.sv
// Multi-channel push-button debouncer: 2-FF synchronizer, shared sampling tick, per-channel qualification counter.
// Define MULTI_DEBOUNCER_FALL_PULSE_EN to generate fall_pulse; otherwise it is tied to 0.
module multi_debouncer #(
    parameter int N_CH       = 4,
    parameter int TICK_DIV   = 100000,
    parameter int STABLE_CNT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] button,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic            tick
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CNT - 1);

    logic [N_CH-1:0] meta;
    logic [N_CH-1:0] sync;
    logic [TW-1:0]   tick_cnt;
    logic [CW-1:0]   cnt      [N_CH];
    logic [CW-1:0]   cnt_next [N_CH];
    logic [N_CH-1:0] accept;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= button;
            sync <= meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick     <= (tick_cnt == TICK_LAST);
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
        end
    end

    // NOTE: every always_comb output gets a default first, so no latch can be inferred.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_next[i] = cnt[i];
            accept[i]   = 1'b0;
            if (tick) begin
                if (sync[i] == level[i]) begin
                    cnt_next[i] = '0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt_next[i] = '0;
                    accept[i]   = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // Pulses are registered alongside level so they coincide with the first cycle of the new level.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
            level      <= '0;
            rise_pulse <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) cnt[i] <= cnt_next[i];
            level      <= level ^ accept;
            rise_pulse <= accept & sync;
        end
    end

`ifdef MULTI_DEBOUNCER_FALL_PULSE_EN
    always_ff @(posedge clk) begin
        if (rst) fall_pulse <= '0;
        else     fall_pulse <= accept & ~sync;
    end
`else
    assign fall_pulse = '0;
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer with N_CH=4, TICK_DIV=4, STABLE_CNT=3.
// Edge numbers below count posedges since the last reset release; channels evaluate on edges 5, 9, 13, ...
module tb_multi_debouncer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] button = 4'hF;
    logic [3:0] level, rise_pulse, fall_pulse;
    logic       tick;

    int vectors     = 0;
    int miscompares = 0;
    int e           = 0;

`ifdef MULTI_DEBOUNCER_FALL_PULSE_EN
    localparam bit FALL_EN = 1'b1;
`else
    localparam bit FALL_EN = 1'b0;
`endif

    multi_debouncer #(.N_CH(4), .TICK_DIV(4), .STABLE_CNT(3)) dut (
        .clk(clk), .rst(rst), .button(button), .level(level),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .tick(tick)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic [3:0] lv, input logic [3:0] rp, input logic [3:0] fp);
        check({tag, ".level"}, 32'(level), 32'(lv));
        check({tag, ".rise"},  32'(rise_pulse), 32'(rp));
        check({tag, ".fall"},  32'(fall_pulse), FALL_EN ? 32'(fp) : 32'h0);
    endtask

    task automatic adv_to(input int target);
        while (e < target) begin
            @(posedge clk);
            e++;
        end
        #1;
    endtask

    // Advance edge by edge, checking rise_pulse stays low throughout.
    task automatic quiet_to(input string tag, input int target);
        while (e < target) begin
            adv_to(e + 1);
            check(tag, 32'(rise_pulse), 32'h0);
        end
    endtask

    initial begin
        // Reset with all buttons high
        repeat (5) begin
            @(posedge clk); #1;
            outs("reset", 4'h0, 4'h0, 4'h0);
            check("reset.tick", 32'(tick), 32'h0);
        end
        rst = 1'b0;
        e = 0;

        // First tick appears after the 4th non-reset edge
        for (int k = 1; k <= 3; k++) begin
            adv_to(k);
            check("tick_early", 32'(tick), 32'h0);
        end
        adv_to(4);  check("tick_first", 32'(tick), 32'h1);
        adv_to(5);  check("tick_width", 32'(tick), 32'h0);
        adv_to(8);  check("tick_period", 32'(tick), 32'h1);

        // Button held through reset re-qualifies from zero
        adv_to(12); outs("held_pre", 4'h0, 4'h0, 4'h0);
        adv_to(13); outs("held_acc", 4'hF, 4'hF, 4'h0);
        adv_to(14); outs("held_post", 4'hF, 4'h0, 4'h0);

        // Release all: fall on every channel
        button = 4'h0;
        adv_to(24); outs("relall_pre", 4'hF, 4'h0, 4'h0);
        adv_to(25); outs("relall_acc", 4'h0, 4'h0, 4'hF);
        adv_to(26); outs("relall_post", 4'h0, 4'h0, 4'h0);

        // Single-channel rise on button[0]
        button = 4'h1;
        adv_to(36); outs("ch0_pre", 4'h0, 4'h0, 4'h0);
        adv_to(37); outs("ch0_acc", 4'h1, 4'h1, 4'h0);
        adv_to(38); outs("ch0_post", 4'h1, 4'h0, 4'h0);

        // Glitch on button[1]: two ticks high then low, count must restart
        button = 4'h3;
        quiet_to("glitch_quiet", 45);
        button = 4'h1;
        quiet_to("glitch_quiet", 49);
        outs("glitch_drop", 4'h1, 4'h0, 4'h0);
        button = 4'h3;
        quiet_to("requal_quiet", 60);
        check("requal_level", 32'(level), 32'h1);
        adv_to(61); outs("requal_acc", 4'h3, 4'h2, 4'h0);
        adv_to(62); outs("requal_post", 4'h3, 4'h0, 4'h0);

        // Drop button[0] so channels 0 and 2 can rise together
        button = 4'h2;
        adv_to(73); outs("ch0_fall", 4'h2, 4'h0, 4'h1);
        adv_to(74); outs("ch0_fall_post", 4'h2, 4'h0, 4'h0);
        button = 4'h7;
        adv_to(84); outs("dual_pre", 4'h2, 4'h0, 4'h0);
        adv_to(85); outs("dual_acc", 4'h7, 4'h5, 4'h0);
        adv_to(86); outs("dual_post", 4'h7, 4'h0, 4'h0);

        // Channel 3 rises, then is released
        button = 4'hF;
        adv_to(97);  outs("ch3_rise", 4'hF, 4'h8, 4'h0);
        adv_to(98);  outs("ch3_rise_post", 4'hF, 4'h0, 4'h0);
        button = 4'h7;
        adv_to(108); outs("ch3_fall_pre", 4'hF, 4'h0, 4'h0);
        adv_to(109); outs("ch3_fall", 4'h7, 4'h0, 4'h8);
        adv_to(110); outs("ch3_fall_post", 4'h7, 4'h0, 4'h0);

        // Reset mid-qualification on button[0] discards the partial count
        button = 4'h6;
        adv_to(121); outs("pre_rst_fall", 4'h6, 4'h0, 4'h1);
        adv_to(122);
        button = 4'h7;
        adv_to(129); outs("two_ticks", 4'h6, 4'h0, 4'h0);
        rst = 1'b1;
        adv_to(130);
        outs("midrst", 4'h0, 4'h0, 4'h0);
        check("midrst.tick", 32'(tick), 32'h0);
        rst = 1'b0;
        e = 0;
        quiet_to("post_rst_quiet", 12);
        check("post_rst_level", 32'(level), 32'h0);
        adv_to(13); outs("post_rst_acc", 4'h7, 4'h7, 4'h0);
        adv_to(14); outs("post_rst_post", 4'h7, 4'h0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
